// File: rtl/signed_dot_accum.sv
// signed_dot_accum: saturating signed accumulator for LEN multiplier products.
// It takes one product per in_valid/in_ready handshake and, after LEN
// products, presents the clamped sum and a sticky overflow flag on a
// valid/ready output port.
module signed_dot_accum #(
  parameter int WIDTH = 6,
  parameter int ACC_W = 20,
  parameter int LEN   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic               out_ovf
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [CW-1:0]     cnt;
  logic              ovf;

  logic              accept;
  logic              last;
  logic              release_out;
  logic [ACC_W:0]    sum;
  logic              sat_hit;
  logic [ACC_W-1:0]  acc_sat;
  logic              ovf_nxt;

  // Sign-extended add with clamping to the ACC_W-bit signed range
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - 2*WIDTH){in_p[2*WIDTH-1]}}, in_p};
    sat_hit = (sum[ACC_W] != sum[ACC_W-1]);
    if (!sat_hit) begin
      acc_sat = sum[ACC_W-1:0];
    end else if (sum[ACC_W]) begin
      acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
    ovf_nxt = ovf | sat_hit;
  end

  // Next-state and handshake outputs; clear overrides every handshake
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    release_out = 1'b0;
    last        = (cnt == CW'(LEN - 1));
    case (state)
      IDLE: begin
        state_nxt = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        accept   = in_valid & ~clear;
        if (accept && last) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        out_valid   = 1'b1;
        release_out = out_ready & ~clear;
        if (clear || out_ready) begin
          state_nxt = ACC;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (clear) begin
      state_nxt = ACC;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator, product counter, sticky flag and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
    end else if (clear || release_out) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_sat;
      cnt <= cnt + CW'(1);
      ovf <= ovf_nxt;
      if (last) begin
        out_acc <= acc_sat;
        out_ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_signed_dot_accum.sv
// Testbench for signed_dot_accum: two instances (ACC_W=20 and ACC_W=12) share
// all inputs and run in lockstep; results are compared against a saturating
// integer-sum reference model.
module tb_signed_dot_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [11:0] in_p;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [19:0] out_acc0;
  logic [11:0] out_acc1;
  logic        out_ovf0, out_ovf1;

  int checks   = 0;
  int failures = 0;

  signed_dot_accum #(.WIDTH(6), .ACC_W(20), .LEN(8)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
    .in_p(in_p), .out_valid(out_valid0), .out_ready(out_ready), .out_acc(out_acc0),
    .out_ovf(out_ovf0)
  );

  signed_dot_accum #(.WIDTH(6), .ACC_W(12), .LEN(8)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .in_p(in_p), .out_valid(out_valid1), .out_ready(out_ready), .out_acc(out_acc1),
    .out_ovf(out_ovf1)
  );

  always #5 clk = ~clk;

  // Reference: plain integer running sum, clamped after each product
  function automatic longint model(input longint p[$], input int accw, output bit ovf);
    longint s;
    longint mx;
    longint mn;
    s   = 0;
    ovf = 1'b0;
    mx  = (longint'(1) <<< (accw - 1)) - 1;
    mn  = -(longint'(1) <<< (accw - 1));
    foreach (p[k]) begin
      s = s + p[k];
      if (s > mx) begin
        s = mx; ovf = 1'b1;
      end else if (s < mn) begin
        s = mn; ovf = 1'b1;
      end
    end
    return s;
  endfunction

  // Offer the queued products, optionally with random idle gaps
  task automatic feed(input longint p[$], input int gap_pct, output bit to);
    int i;
    int guard;
    i = 0; guard = 0; to = 1'b0;
    while (i < p.size()) begin
      if (guard >= 500) begin
        to = 1'b1;
        break;
      end
      if (!(in_valid && !in_ready0)) begin
        if (int'($urandom_range(99)) < gap_pct) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_p     = 12'(p[i]);
        end
      end
      if (in_valid && in_ready0) i++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
  endtask

  // Wait for a result, capture it, then complete the output handshake
  task automatic get_result(output logic [19:0] a0, output logic [11:0] a1,
                            output logic v0, output logic v1,
                            output int waited, output bit to);
    waited = 0; to = 1'b0;
    while (!out_valid0 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!out_valid0) to = 1'b1;
    a0 = out_acc0; a1 = out_acc1; v0 = out_ovf0; v1 = out_ovf1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_p = '0; out_ready = 1'b0;
    #1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b/%b exp=0/0", out_valid0, out_valid1);
    end
    checks++;
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b/%b exp=0/0", in_ready0, in_ready1);
    end
    checks++;
    if (out_acc0 !== 20'd0 || out_acc1 !== 12'd0 || out_ovf0 !== 1'b0 || out_ovf1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h ovf=%b/%b exp=0/0 ovf=0/0", out_acc0, out_acc1, out_ovf0, out_ovf1);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int cycles;
    int accepts;
    cycles = 0; accepts = 0;
    checks++;
    if (in_ready0 !== 1'b0) begin
      failures++; $display("FAIL basic_idle_ready got=%b exp=0", in_ready0);
    end
    in_valid = 1'b1; in_p = 12'd1;
    while (accepts < 8 && cycles < 50) begin
      if (in_ready0) accepts++;
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (cycles != 9) begin
      failures++; $display("FAIL basic_latency got=%0d cycles exp=9", cycles);
    end
    checks++;
    if (out_valid0 !== 1'b1) begin
      failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid0);
    end
    checks++;
    if (out_acc0 !== 20'd8 || out_ovf0 !== 1'b0 || out_acc1 !== 12'd8 || out_ovf1 !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got=%0d/%0d ovf=%b/%b exp=8/8 ovf=0/0", out_acc0, out_acc1, out_ovf0, out_ovf1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      failures++; $display("FAIL basic_release got valid=%b ready=%b exp valid=0 ready=1", out_valid0, in_ready0);
    end
  endtask

  task automatic test_random;
    longint q[$];
    int vec[8] = '{1024, -1024, 35, -6, 0, 0, 0, 0};
    logic [19:0] a0;
    logic [11:0] a1;
    logic v0, v1;
    bit e0v, e1v, to_f, to_r;
    longint e0, e1;
    int waited;
    int a, b;
    for (int g = 0; g < 7; g++) begin
      q.delete();
      if (g == 0) begin
        foreach (vec[k]) q.push_back(longint'(vec[k]));
      end else begin
        for (int k = 0; k < 8; k++) begin
          a = int'($urandom_range(63)); if (a > 31) a = a - 64;
          b = int'($urandom_range(63)); if (b > 31) b = b - 64;
          q.push_back(longint'(a * b));
        end
      end
      e0 = model(q, 20, e0v);
      e1 = model(q, 12, e1v);
      feed(q, (g == 0) ? 0 : 30, to_f);
      get_result(a0, a1, v0, v1, waited, to_r);
      checks++;
      if (to_f || to_r || waited != 0) begin
        failures++; $display("FAIL rand_timing grp=%0d feed_to=%b res_to=%b waited=%0d exp waited=0", g, to_f, to_r, waited);
      end
      checks++;
      if (a0 !== 20'(e0) || v0 !== e0v) begin
        failures++; $display("FAIL rand_acc20 grp=%0d got=%0d ovf=%b exp=%0d ovf=%b", g, $signed(a0), v0, e0, e0v);
      end
      checks++;
      if (a1 !== 12'(e1) || v1 !== e1v) begin
        failures++; $display("FAIL rand_acc12 grp=%0d got=%0d ovf=%b exp=%0d ovf=%b", g, $signed(a1), v1, e1, e1v);
      end
    end
  endtask

  task automatic test_backpressure;
    longint q[$];
    logic [19:0] a0;
    logic [11:0] a1;
    logic v0, v1;
    bit ev, to_f, to_r;
    longint e;
    int waited;
    q.delete();
    for (int k = 0; k < 8; k++) q.push_back(longint'($urandom_range(200)) - 100);
    e = model(q, 20, ev);
    feed(q, 0, to_f);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_p      = 12'd5;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (to_f || out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_acc0 !== 20'(e) || out_ovf0 !== ev) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b acc=%0d ovf=%b exp valid=1 ready=0 acc=%0d ovf=%b",
                 k, out_valid0, in_ready0, $signed(out_acc0), out_ovf0, e, ev);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid0, in_ready0);
    end
    q.delete();
    repeat (8) q.push_back(5);
    feed(q, 0, to_f);
    get_result(a0, a1, v0, v1, waited, to_r);
    checks++;
    if (to_f || to_r || waited != 0 || a0 !== 20'd40 || a1 !== 12'd40) begin
      failures++;
      $display("FAIL bp_next_group got=%0d/%0d waited=%0d exp=40/40 waited=0", $signed(a0), $signed(a1), waited);
    end
  endtask

  task automatic test_saturation;
    longint q[$];
    logic [19:0] a0;
    logic [11:0] a1;
    logic v0, v1;
    bit to_f, to_r;
    int waited;
    q.delete();
    q.push_back(1024); q.push_back(1024); q.push_back(-1024);
    repeat (5) q.push_back(0);
    feed(q, 20, to_f);
    get_result(a0, a1, v0, v1, waited, to_r);
    checks++;
    if (to_f || to_r || a1 !== 12'd1023 || v1 !== 1'b1) begin
      failures++; $display("FAIL sat_pos12 got=%0d ovf=%b exp=1023 ovf=1", $signed(a1), v1);
    end
    checks++;
    if (a0 !== 20'd1024 || v0 !== 1'b0) begin
      failures++; $display("FAIL sat_pos20 got=%0d ovf=%b exp=1024 ovf=0", $signed(a0), v0);
    end
    q.delete();
    repeat (8) q.push_back(-1024);
    feed(q, 20, to_f);
    get_result(a0, a1, v0, v1, waited, to_r);
    checks++;
    if (to_f || to_r || a1 !== 12'h800 || v1 !== 1'b1) begin
      failures++; $display("FAIL sat_neg12 got=%0d ovf=%b exp=-2048 ovf=1", $signed(a1), v1);
    end
    checks++;
    if (a0 !== 20'(-8192) || v0 !== 1'b0) begin
      failures++; $display("FAIL sat_neg20 got=%0d ovf=%b exp=-8192 ovf=0", $signed(a0), v0);
    end
    q.delete();
    repeat (8) q.push_back(-7);
    feed(q, 0, to_f);
    get_result(a0, a1, v0, v1, waited, to_r);
    checks++;
    if (to_f || to_r || a1 !== 12'(-56) || v1 !== 1'b0) begin
      failures++; $display("FAIL sat_ovf_cleared got=%0d ovf=%b exp=-56 ovf=0", $signed(a1), v1);
    end
  endtask

  task automatic test_clear;
    longint q[$];
    logic [19:0] a0;
    logic [11:0] a1;
    logic v0, v1;
    bit to_f, to_r;
    int waited;
    q.delete();
    repeat (4) q.push_back(2);
    feed(q, 0, to_f);
    in_valid = 1'b1; in_p = 12'd100; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      failures++; $display("FAIL clear_acc_state got ready=%b valid=%b exp ready=1 valid=0", in_ready0, out_valid0);
    end
    q.delete();
    repeat (8) q.push_back(2);
    feed(q, 0, to_f);
    get_result(a0, a1, v0, v1, waited, to_r);
    checks++;
    if (to_f || to_r || waited != 0 || a0 !== 20'd16 || a1 !== 12'd16) begin
      failures++; $display("FAIL clear_drop got=%0d/%0d waited=%0d exp=16/16 waited=0", $signed(a0), $signed(a1), waited);
    end
    q.delete();
    repeat (8) q.push_back(3);
    feed(q, 0, to_f);
    checks++;
    if (to_f || out_valid0 !== 1'b1 || out_acc0 !== 20'd24) begin
      failures++; $display("FAIL clear_pre_out got valid=%b acc=%0d exp valid=1 acc=24", out_valid0, $signed(out_acc0));
    end
    out_ready = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready0 !== 1'b1) begin
      failures++; $display("FAIL clear_in_out got valid=%b/%b ready=%b exp valid=0/0 ready=1", out_valid0, out_valid1, in_ready0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid0 !== 1'b0) begin
        failures++; $display("FAIL clear_no_result cyc=%0d got=%b exp=0", k, out_valid0);
      end
    end
    out_ready = 1'b0;
    q.delete();
    repeat (8) q.push_back(1);
    feed(q, 25, to_f);
    get_result(a0, a1, v0, v1, waited, to_r);
    checks++;
    if (to_f || to_r || a0 !== 20'd8 || a1 !== 12'd8) begin
      failures++; $display("FAIL clear_restart got=%0d/%0d exp=8/8", $signed(a0), $signed(a1));
    end
  endtask

  task automatic test_async_reset;
    longint q[$];
    logic [19:0] a0;
    logic [11:0] a1;
    logic v0, v1;
    bit to_f, to_r;
    int waited;
    q.delete();
    repeat (5) q.push_back(-3);
    feed(q, 0, to_f);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (to_f || in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || out_acc0 !== 20'd0 || out_acc1 !== 12'd0) begin
      failures++;
      $display("FAIL async_rst got ready=%b valid=%b acc=%0d/%0d exp ready=0 valid=0 acc=0/0",
               in_ready0, out_valid0, out_acc0, out_acc1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    repeat (8) q.push_back(-3);
    feed(q, 10, to_f);
    get_result(a0, a1, v0, v1, waited, to_r);
    checks++;
    if (to_f || to_r || a0 !== 20'(-24) || a1 !== 12'(-24) || v0 !== 1'b0 || v1 !== 1'b0) begin
      failures++;
      $display("FAIL async_fresh got=%0d/%0d ovf=%b/%b exp=-24/-24 ovf=0/0", $signed(a0), $signed(a1), v0, v1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
